// File: rtl/order_book_table.sv
// Live-order table: one decoded order object per DEPTH+2 cycles.
// A sequential scan finds free/matching entries; COMMIT does the single write.
module order_book_table #(
  parameter int DEPTH = 16,
  parameter int IDX_W = $clog2(DEPTH),
  parameter int CNT_W = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             obj_valid,
  input  logic [161:0]     obj_data,
  output logic             obj_ready,
  output logic             res_valid,
  output logic [1:0]       res_type,
  output logic [1:0]       res_status,
  output logic [31:0]      res_order_id,
  output logic [31:0]      res_qty,
  output logic [CNT_W-1:0] order_count
);

  localparam logic [1:0] T_ADD = 2'b00;
  localparam logic [1:0] T_CAN = 2'b01;
  localparam logic [1:0] T_EXE = 2'b10;
  localparam logic [1:0] T_CLR = 2'b11;

  localparam logic [1:0] S_OK  = 2'b00;
  localparam logic [1:0] S_NF  = 2'b01;
  localparam logic [1:0] S_FUL = 2'b10;
  localparam logic [1:0] S_DUP = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    COMMIT
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [161:0]      obj_q, obj_d;
  logic              free_hit_q, free_hit_d;
  logic [IDX_W-1:0]  free_idx_q, free_idx_d;
  logic              match_hit_q, match_hit_d;
  logic [IDX_W-1:0]  match_idx_q, match_idx_d;
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [31:0]       stock_q [DEPTH];
  logic [31:0]       stock_d [DEPTH];
  logic [31:0]       oid_q   [DEPTH];
  logic [31:0]       oid_d   [DEPTH];
  logic [31:0]       qty_q   [DEPTH];
  logic [31:0]       qty_d   [DEPTH];
  logic [63:0]       price_q [DEPTH];
  logic [63:0]       price_d [DEPTH];
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              res_valid_q, res_valid_d;
  logic [1:0]        res_type_q, res_type_d;
  logic [1:0]        res_status_q, res_status_d;
  logic [31:0]       res_oid_q, res_oid_d;
  logic [31:0]       res_qty_q, res_qty_d;

  logic [1:0]        l_typ;
  logic [31:0]       l_oid;
  logic [31:0]       l_qty;
  logic [31:0]       m_qty;

  assign l_typ = obj_q[161:160];
  assign l_oid = obj_q[127:96];
  assign l_qty = obj_q[95:64];
  assign m_qty = qty_q[match_idx_q];

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    obj_d        = obj_q;
    free_hit_d   = free_hit_q;
    free_idx_d   = free_idx_q;
    match_hit_d  = match_hit_q;
    match_idx_d  = match_idx_q;
    valid_d      = valid_q;
    stock_d      = stock_q;
    oid_d        = oid_q;
    qty_d        = qty_q;
    price_d      = price_q;
    cnt_d        = cnt_q;
    res_valid_d  = 1'b0;
    res_type_d   = res_type_q;
    res_status_d = res_status_q;
    res_oid_d    = res_oid_q;
    res_qty_d    = res_qty_q;
    unique case (state_q)
      IDLE: begin
        if (obj_valid) begin
          obj_d       = obj_data;
          idx_d       = '0;
          free_hit_d  = 1'b0;
          match_hit_d = 1'b0;
          state_d     = SCAN;
        end
      end
      SCAN: begin
        if (!valid_q[idx_q] && !free_hit_q) begin
          free_hit_d = 1'b1;
          free_idx_d = idx_q;
        end
        if (valid_q[idx_q] && oid_q[idx_q] == l_oid && !match_hit_q) begin
          match_hit_d = 1'b1;
          match_idx_d = idx_q;
        end
        if (idx_q == IDX_W'(DEPTH-1)) state_d = COMMIT;
        else                          idx_d   = idx_q + 1'b1;
      end
      COMMIT: begin
        state_d      = IDLE;
        res_valid_d  = 1'b1;
        res_type_d   = l_typ;
        res_oid_d    = l_oid;
        res_status_d = S_OK;
        res_qty_d    = '0;
        unique case (l_typ)
          T_ADD: begin
            if (match_hit_q) begin
              res_status_d = S_DUP;
              res_qty_d    = m_qty;
            end else if (!free_hit_q) begin
              res_status_d = S_FUL;
            end else begin
              valid_d[free_idx_q] = 1'b1;
              stock_d[free_idx_q] = obj_q[159:128];
              oid_d[free_idx_q]   = l_oid;
              qty_d[free_idx_q]   = l_qty;
              price_d[free_idx_q] = obj_q[63:0];
              cnt_d               = cnt_q + CNT_W'(1);
              res_qty_d           = l_qty;
            end
          end
          T_CAN: begin
            if (match_hit_q) begin
              valid_d[match_idx_q] = 1'b0;
              cnt_d                = cnt_q - CNT_W'(1);
            end else begin
              res_status_d = S_NF;
            end
          end
          T_EXE: begin
            if (!match_hit_q) begin
              res_status_d = S_NF;
            end else if (l_qty == '0) begin
              res_qty_d = m_qty;
            end else if (l_qty >= m_qty) begin
              valid_d[match_idx_q] = 1'b0;
              cnt_d                = cnt_q - CNT_W'(1);
            end else begin
              qty_d[match_idx_q] = m_qty - l_qty;
              res_qty_d          = m_qty - l_qty;
            end
          end
          T_CLR: begin
            valid_d = '0;
            cnt_d   = '0;
          end
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      obj_q        <= '0;
      free_hit_q   <= 1'b0;
      free_idx_q   <= '0;
      match_hit_q  <= 1'b0;
      match_idx_q  <= '0;
      valid_q      <= '0;
      stock_q      <= '{default: '0};
      oid_q        <= '{default: '0};
      qty_q        <= '{default: '0};
      price_q      <= '{default: '0};
      cnt_q        <= '0;
      res_valid_q  <= 1'b0;
      res_type_q   <= '0;
      res_status_q <= '0;
      res_oid_q    <= '0;
      res_qty_q    <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      obj_q        <= obj_d;
      free_hit_q   <= free_hit_d;
      free_idx_q   <= free_idx_d;
      match_hit_q  <= match_hit_d;
      match_idx_q  <= match_idx_d;
      valid_q      <= valid_d;
      stock_q      <= stock_d;
      oid_q        <= oid_d;
      qty_q        <= qty_d;
      price_q      <= price_d;
      cnt_q        <= cnt_d;
      res_valid_q  <= res_valid_d;
      res_type_q   <= res_type_d;
      res_status_q <= res_status_d;
      res_oid_q    <= res_oid_d;
      res_qty_q    <= res_qty_d;
    end
  end

  assign obj_ready    = (state_q == IDLE);
  assign res_valid    = res_valid_q;
  assign res_type     = res_type_q;
  assign res_status   = res_status_q;
  assign res_order_id = res_oid_q;
  assign res_qty      = res_qty_q;
  assign order_count  = cnt_q;

endmodule

// File: doc/order_book_table.md
# order_book_table

Order-tracking stage directly downstream of the order-book parser. It accepts one 162-bit decoded order object at a time and applies it to a fixed-depth on-chip table of live orders: add, cancel, execute (partial or full fill) or clear. It reports one result per object with status and remaining quantity. A sequential scan FSM keeps the table to a single write port and no wide parallel comparators.

## Interface
- DEPTH, 16: number of table entries (power of 2, 2..64).
- IDX_W, $clog2(DEPTH): entry index width.
- CNT_W, $clog2(DEPTH+1): order_count width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- obj_valid  in  1  obj_data valid; consumed when obj_valid & obj_ready at a rising edge.
- obj_data  in  162  object fields:
  - [161:160] msg type: 00 add, 01 cancel, 10 execute, 11 clear.
  - [159:128] stock id.
  - [127:96] order id.
  - [95:64] quantity.
  - [63:0] price.
- obj_ready  out  1  high only in IDLE.
- res_valid  out  1  one-cycle result pulse.
- res_type  out  2  msg type of the finished object.
- res_status  out  2  00 OK, 01 NOT_FOUND, 10 FULL, 11 DUPLICATE.
- res_order_id  out  32  order id of the finished object.
- res_qty  out  32  quantity left in the table for that order after the op; 0 if removed, failed or clear.
- order_count  out  CNT_W  number of valid entries.

## Operation
- Entry fields: valid, stock[32], order_id[32], qty[32], price[64].
- FSM states: IDLE, SCAN, COMMIT.
  - IDLE -> SCAN on accept; the object is latched and scan index = 0.
  - SCAN examines entry[idx] once per cycle, for DEPTH cycles.
    - Records the lowest-index free entry.
    - Records the lowest-index valid entry with order_id equal to the latched id. Stock is not compared.
  - SCAN -> COMMIT after idx = DEPTH-1; idx does not wrap.
  - COMMIT applies the op, pulses res_valid, then goes to IDLE.
- Add:
  - If a match exists: DUPLICATE, table unchanged, res_qty = stored qty.
  - Else if no free entry: FULL, table unchanged.
  - Else write the lowest free entry, OK, res_qty = qty, order_count+1.
- Cancel:
  - Match: invalidate it, OK, res_qty 0, order_count-1.
  - No match: NOT_FOUND.
- Execute:
  - No match: NOT_FOUND.
  - Exec qty >= stored qty: invalidate the entry, OK, res_qty 0, order_count-1.
  - Otherwise: stored qty -= exec qty, OK, res_qty = remainder.
  - Subtraction is 32-bit unsigned and never underflows.
- Clear: all entries invalidated in COMMIT, order_count 0, OK. The scan still runs so latency is uniform.
- Exec qty 0 on a matching entry: OK, stored qty unchanged, res_qty = stored qty.
- Add with qty 0 is stored as given.
- order_count changes only in COMMIT, in the same edge as the table write.

## Timing
- Reset (asynchronous, any state):
  - State IDLE, obj_ready 1, res_valid 0, res_type/res_status/res_order_id/res_qty 0, order_count 0, all entries invalid.
  - An in-flight object is dropped with no result.
- Accept at edge E0. SCAN occupies the cycles after edges E1..E_DEPTH; COMMIT at edge E_(DEPTH+1).
- Outputs after edge E_(DEPTH+1):
  - res_valid high for exactly one cycle, with res_* stable during it.
  - obj_ready high again in that same cycle.
- Latency: accept to res_valid = DEPTH+1 cycles. Throughput: one object per DEPTH+2 cycles.
- obj_valid while obj_ready = 0 is ignored. Upstream holds data until accepted.
- res_* fields hold their values after the pulse until the next COMMIT.
- No back-pressure on results; the consumer must take the pulse.

## Test plan
- Reset, DEPTH=16:
  - Add id 0x11, qty 100, price 5000 -> res_valid 17 cycles after accept, OK, res_qty 100, order_count 1.
  - obj_ready low for the 17 cycles between.
- Add id 0x11 again -> DUPLICATE, res_qty 100, count 1.
- Execute id 0x11, qty 30 -> OK, res_qty 70.
- Then execute id 0x11, qty 200 -> OK, res_qty 0, count 0.
- Cancel id 0x99 -> NOT_FOUND.
- Fill the table:
  - Add 16 distinct ids -> each OK, count 16.
  - 17th add -> FULL, count 16.
  - Cancel entry 3, then add a new id -> lands in index 3 (check by cancelling it: OK).
- Clear with 16 valid entries -> OK, order_count 0. Cancel of any former id -> NOT_FOUND.
- Assert resetn low mid-SCAN of an add -> no res_valid, obj_ready 1 immediately, count 0, previous orders gone.
